mul8_sequencer: RTL and testbench



---
 rtl/mul8_sequencer.sv | 153 +++++++++++++++
 tb/tb_mul8_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mul8_sequencer.sv
// Two-port round-robin front end for the shared nibble multiplier.
// Builds a 16-bit product from four 4x4 partial products.
module mul8_sequencer #(
    parameter int UUID = 0,
    parameter     NAME = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic [7:0]  mul_in1,
    output logic [7:0]  mul_in2,
    input  logic [7:0]  mul_out,
    output logic        res_valid,
    output logic        res_id,
    output logic [15:0] res_product,
    input  logic        res_ready
);

    localparam int unsigned DW = 8;
    localparam int unsigned NW = 4;
    localparam int unsigned PW = 16;
    localparam int unsigned SW = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Instance metadata carries no logic; referenced so it elaborates cleanly.
    if (UUID < 0 && $bits(NAME) == 0) begin : g_meta
    end

    state_t        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic          id_q, id_d;
    logic          last_q, last_d;
    logic          res_valid_d;
    logic          res_id_d;
    logic [PW-1:0] res_product_d;

    logic          grant_any;
    logic          grant_id;
    logic [NW-1:0] a_nib;
    logic [NW-1:0] b_nib;
    logic [3:0]    shamt;
    logic [PW-1:0] partial;
    logic [PW-1:0] sum;

    // Tie goes to the requester not served last.
    assign grant_any = req0_valid | req1_valid;
    assign grant_id  = (req0_valid & req1_valid) ? ~last_q : req1_valid;

    // Step order: lo*lo, lo*hi, hi*lo, hi*hi; shift 0, 4, 4, 8.
    assign a_nib   = step_q[1] ? a_q[7:4] : a_q[3:0];
    assign b_nib   = step_q[0] ? b_q[7:4] : b_q[3:0];
    assign shamt   = {step_q[1] & step_q[0], step_q[1] ^ step_q[0], 2'b00};
    assign partial = PW'(mul_out) << shamt;
    assign sum     = acc_q + partial;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            res_valid   <= 1'b0;
            res_id      <= 1'b0;
            res_product <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            last_q      <= last_d;
            res_valid   <= res_valid_d;
            res_id      <= res_id_d;
            res_product <= res_product_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        acc_d         = acc_q;
        a_d           = a_q;
        b_d           = b_q;
        id_d          = id_q;
        last_d        = last_q;
        res_valid_d   = res_valid;
        res_id_d      = res_id;
        res_product_d = res_product;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        mul_in1       = '0;
        mul_in2       = '0;

        case (state_q)
            ST_IDLE: begin
                req0_ready = ~rst & grant_any & ~grant_id;
                req1_ready = ~rst & grant_any & grant_id;
                if (grant_any) begin
                    a_d     = grant_id ? req1_a : req0_a;
                    b_d     = grant_id ? req1_b : req0_b;
                    id_d    = grant_id;
                    last_d  = grant_id;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (!rst) begin
                    mul_in1 = {4'h0, a_nib};
                    mul_in2 = {4'h0, b_nib};
                end
                acc_d  = sum;
                step_d = SW'(step_q + SW'(1));
                if (step_q == SW'(3)) begin
                    res_product_d = sum;
                    res_valid_d   = 1'b1;
                    res_id_d      = id_q;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul8_sequencer.sv
// Bench for mul8_sequencer: directed cases plus random traffic checked
// against an arithmetic reference (a*b, nibble schedule, round-robin rule).
module tb_mul8_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [7:0]  mul_in1, mul_in2, mul_out;
    logic        res_valid, res_id, res_ready;
    logic [15:0] res_product;

    int n_checks = 0;
    int n_fail   = 0;
    bit last_served;

    always #5 clk = ~clk;

    // Behavioural stand-in for the external multiplier.
    assign mul_out = 8'(mul_in1 * mul_in2);

    mul8_sequencer #(.UUID(0), .NAME("tb")) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out),
        .res_valid(res_valid), .res_id(res_id), .res_product(res_product),
        .res_ready(res_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick(input bit v0, input bit v1);
        return (v0 && v1) ? !last_served : v1;
    endfunction

    task automatic drive(input bit id, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_served = 1'b1;
    endtask

    // Serve one already-driven request, holding res_ready low for 'hold' cycles.
    task automatic serve(input bit id, input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [31:0] prod;
        prod = 32'(a) * 32'(b);
        res_ready = (hold == 0);
        #1;
        chk("ready_win", 32'(id ? req1_ready : req0_ready), 32'd1);
        chk("ready_lose", 32'(id ? req0_ready : req1_ready), 32'd0);
        tick();
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        last_served = id;
        #1;
        for (int s = 0; s < 4; s++) begin
            chk("mul_in1", 32'(mul_in1), (s < 2) ? 32'(a % 16) : 32'(a / 16));
            chk("mul_in2", 32'(mul_in2), (s % 2 == 0) ? 32'(b % 16) : 32'(b / 16));
            chk("busy_valid", 32'(res_valid), 32'd0);
            chk("busy_ready", 32'({req0_ready, req1_ready}), 32'd0);
            tick();
        end
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_product", 32'(res_product), prod);
        chk("res_id", 32'(res_id), 32'(id));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_product", 32'(res_product), prod);
            chk("bp_id", 32'(res_id), 32'(id));
            chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
            chk("bp_mul", 32'({mul_in1, mul_in2}), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("released", 32'(res_valid), 32'd0);
        chk("held_product", 32'(res_product), prod);
    endtask

    initial begin
        logic [7:0] ra, rb, sa, sb;
        int mode, hold;
        bit w;

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        res_ready = 1'b0;
        last_served = 1'b1;
        tick();
        req0_valid = 1'b1;
        #1;
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        tick();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_product", 32'(res_product), 32'd0);
        chk("rst_mul", 32'({mul_in1, mul_in2}), 32'd0);
        rst = 1'b0;
        req0_valid = 1'b0;
        tick();

        drive(0, 8'hA5, 8'h3C);
        serve(0, 8'hA5, 8'h3C, 0);
        chk("a5x3c_const", 32'(res_product), 32'h26AC);

        drive(0, 8'hFF, 8'hFF);
        serve(0, 8'hFF, 8'hFF, 0);
        chk("ffxff_const", 32'(res_product), 32'hFE01);
        drive(1, 8'h00, 8'h9C);
        serve(1, 8'h00, 8'h9C, 1);

        // Tie from reset: requester 0 first, then 1, then 0 again.
        do_reset();
        drive(0, 8'h12, 8'h34);
        drive(1, 8'hAB, 8'hCD);
        chk("tie_pick", 32'(pick(1'b1, 1'b1)), 32'd0);
        serve(0, 8'h12, 8'h34, 3);
        chk("tie_first", 32'(res_product), 32'h03A8);
        serve(1, 8'hAB, 8'hCD, 0);
        chk("tie_second", 32'(res_product), 32'h88EF);
        drive(0, 8'h12, 8'h34);
        drive(1, 8'hAB, 8'hCD);
        serve(pick(1'b1, 1'b1), 8'h12, 8'h34, 0);
        serve(1, 8'hAB, 8'hCD, 0);

        // Abort at MUL step2.
        drive(0, 8'h77, 8'h88);
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        chk("abort_step2_in1", 32'(mul_in1), 32'h07);
        chk("abort_step2_in2", 32'(mul_in2), 32'h08);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_served = 1'b1;
        chk("abort_valid", 32'(res_valid), 32'd0);
        chk("abort_mul", 32'({mul_in1, mul_in2}), 32'd0);
        drive(0, 8'h01, 8'h01);
        drive(1, 8'h01, 8'h01);
        #1;
        chk("abort_ptr", 32'({req0_ready, req1_ready}), 32'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_result", 32'(res_valid), 32'd0);
        end
        res_ready = 1'b0;
        drive(0, 8'h02, 8'h03);
        serve(0, 8'h02, 8'h03, 0);
        chk("after_abort", 32'(res_product), 32'h0006);

        // Random traffic.
        for (int it = 0; it < 24; it++) begin
            mode = int'($urandom_range(0, 2));
            hold = int'($urandom_range(0, 3));
            ra = 8'($urandom); rb = 8'($urandom);
            sa = 8'($urandom); sb = 8'($urandom);
            if (mode == 0) begin
                drive(0, ra, rb);
                serve(0, ra, rb, hold);
            end else if (mode == 1) begin
                drive(1, ra, rb);
                serve(1, ra, rb, hold);
            end else begin
                drive(0, ra, rb);
                drive(1, sa, sb);
                w = pick(1'b1, 1'b1);
                serve(w, w ? sa : ra, w ? sb : rb, hold);
                serve(!w, w ? ra : sa, w ? rb : sb, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
